// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB init sequencer and the SCCB master:
// table op codes, WR encodings, entry field positions and the FSM state type.
package sccb_pkg;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_VERIFY = 2'b01;
  localparam logic [1:0] OP_DELAY  = 2'b10;
  localparam logic [1:0] OP_END    = 2'b11;

  // WR[1:0] transaction kind, WR[3:2] register address width
  localparam logic [1:0] WR_WRITE  = 2'b00;
  localparam logic [1:0] WR_RD1    = 2'b01;
  localparam logic [1:0] WR_RD2    = 2'b10;
  localparam logic [1:0] WR_WIDE   = 2'b01;
  localparam logic [1:0] WR_NARROW = 2'b00;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 30;
  localparam int WIDE_BIT  = 29;
  localparam int REG_MSB   = 23;
  localparam int REG_LSB   = 8;
  localparam int DAT_MSB   = 7;
  localparam int DAT_LSB   = 0;
  localparam int TICKS_MSB = 23;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, ISSUE, ACK, XFER, GAP,
    RD2_ISSUE, RD2_ACK, RD2_XFER, CMP, DELAY, FIN
  } state_t;

  function automatic logic [31:0] sccb_word(input logic [6:0] id, input logic wide,
                                            input logic [15:0] reg_addr, input logic [7:0] dat);
    return wide ? {id, 1'b0, reg_addr, dat} : {id, 1'b0, reg_addr[7:0], dat, 8'h00};
  endfunction

endpackage

// File: rtl/sccb_init_seq_if.sv
// Table ROM port and SCCB master handshake seen by the init sequencer.
interface sccb_init_seq_if #(parameter int ADDR_W = 8);
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_data;
  logic              sccb_start;
  logic [3:0]        sccb_wr;
  logic [31:0]       sccb_data;
  logic              sccb_busy;
  logic [7:0]        sccb_rdata;

  modport master (output rom_addr, sccb_start, sccb_wr, sccb_data,
                  input  rom_data, sccb_busy, sccb_rdata);
  modport slave  (input  rom_addr, sccb_start, sccb_wr, sccb_data,
                  output rom_data, sccb_busy, sccb_rdata);
endinterface

// File: rtl/tick_timer.sv
// Down-counter for inter-transaction gaps (clk rate) and table delays (tick rate).
// expired is high during the last cycle of the loaded interval.
module tick_timer #(
  parameter int TICK_DIV = 100000,
  parameter int CNT_W    = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load,
  input  logic             tick_mode,
  input  logic [CNT_W-1:0] count,
  output logic             expired
);
  localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [PRE_W-1:0] pre;
  logic             mode;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt  <= '0;
      pre  <= '0;
      mode <= 1'b0;
    end else if (load) begin
      cnt  <= count;
      pre  <= tick_mode ? PRE_MAX : '0;
      mode <= tick_mode;
    end else if (cnt != '0) begin
      if (pre == '0) begin
        cnt <= cnt - CNT_W'(1);
        pre <= mode ? PRE_MAX : '0;
      end else begin
        pre <= pre - PRE_W'(1);
      end
    end
  end

  assign expired = (cnt == CNT_W'(1)) && (pre == '0);

endmodule

// File: rtl/sccb_init_seq.sv
// Table-driven camera init sequencer: fetches command words from a synchronous ROM
// and runs writes, read-back verifies and delays through the SCCB master.
module sccb_init_seq
  import sccb_pkg::*;
#(
  parameter int         ADDR_W   = 8,
  parameter logic [6:0] CAM_ID   = 7'h3C,
  parameter int         TICK_DIV = 100000,
  parameter int         GAP_CYC  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_idx,
  output logic [7:0]        err_rdata,
  sccb_init_seq_if.master   bus
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [3:0]        wr_q;
  logic [31:0]       data_q;
  logic [7:0]        ent_data;
  logic              tmr_load, tmr_tick, tmr_exp;
  logic [23:0]       tmr_count;
  logic [1:0]        op;
  logic              wide, last, adv;
  logic              unused_rsvd;

  assign op          = bus.rom_data[OP_MSB:OP_LSB];
  assign wide        = bus.rom_data[WIDE_BIT];
  assign last        = (idx == {ADDR_W{1'b1}});
  assign unused_rsvd = ^bus.rom_data[28:24];

  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_tick  = 1'b0;
    tmr_count = '0;
    case (state)
      IDLE:   if (go) state_nxt = FETCH;
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (op)
          OP_WRITE, OP_VERIFY: state_nxt = ISSUE;
          OP_DELAY: begin
            if (bus.rom_data[TICKS_MSB:0] == '0) begin
              state_nxt = last ? FIN : FETCH;
            end else begin
              state_nxt = DELAY;
              tmr_load  = 1'b1;
              tmr_tick  = 1'b1;
              tmr_count = bus.rom_data[TICKS_MSB:0];
            end
          end
          default: state_nxt = FIN;
        endcase
      end
      ISSUE:     state_nxt = ACK;
      ACK:       if (bus.sccb_busy) state_nxt = XFER;
      XFER, RD2_XFER: begin
        if (!bus.sccb_busy) begin
          state_nxt = GAP;
          tmr_load  = 1'b1;
          tmr_count = 24'(GAP_CYC);
        end
      end
      // the held WR kind tells which transaction the gap follows
      GAP: begin
        if (tmr_exp) begin
          if (wr_q[1:0] == WR_RD1)      state_nxt = RD2_ISSUE;
          else if (wr_q[1:0] == WR_RD2) state_nxt = CMP;
          else                          state_nxt = last ? FIN : FETCH;
        end
      end
      RD2_ISSUE: state_nxt = RD2_ACK;
      RD2_ACK:   if (bus.sccb_busy) state_nxt = RD2_XFER;
      CMP:       state_nxt = last ? FIN : FETCH;
      DELAY:     if (tmr_exp) state_nxt = last ? FIN : FETCH;
      FIN:       state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign adv = (state_nxt == FETCH) && (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      idx       <= '0;
      wr_q      <= '0;
      data_q    <= '0;
      ent_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      err_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && go) begin
        idx  <= '0;
        done <= 1'b0;
        err  <= 1'b0;
      end
      if (adv) idx <= idx + ADDR_W'(1);
      if (state == DECODE && (op == OP_WRITE || op == OP_VERIFY)) begin
        ent_data <= bus.rom_data[DAT_MSB:DAT_LSB];
        wr_q     <= {wide ? WR_WIDE : WR_NARROW, (op == OP_VERIFY) ? WR_RD1 : WR_WRITE};
        data_q   <= sccb_word(CAM_ID, wide, bus.rom_data[REG_MSB:REG_LSB],
                              bus.rom_data[DAT_MSB:DAT_LSB]);
      end
      if (state_nxt == RD2_ISSUE && state == GAP) begin
        wr_q   <= {wr_q[3:2], WR_RD2};
        data_q <= {CAM_ID, 1'b0, 24'h0};
      end
      if (state_nxt == FIN) done <= 1'b1;
      if (state == CMP && bus.sccb_rdata != ent_data && !err) begin
        err       <= 1'b1;
        err_idx   <= idx;
        err_rdata <= bus.sccb_rdata;
      end
    end
  end

  tick_timer #(.TICK_DIV(TICK_DIV), .CNT_W(24)) u_tmr (
    .clk       (clk),
    .rstn      (rstn),
    .load      (tmr_load),
    .tick_mode (tmr_tick),
    .count     (tmr_count),
    .expired   (tmr_exp)
  );

  assign busy           = (state != IDLE) && (state != FIN);
  assign bus.rom_addr   = idx;
  assign bus.sccb_start = (state == ISSUE) || (state == RD2_ISSUE);
  assign bus.sccb_wr    = wr_q;
  assign bus.sccb_data  = data_q;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: behavioural ROM and SCCB master, table vectors,
// hand-written timing sequences and randomized tables against a table-walk model.
module tb_sccb_init_seq;
  localparam int         ADDR_W   = 3;
  localparam int         N_ENT    = 8;
  localparam int         TICK_DIV = 10;
  localparam int         GAP_CYC  = 4;
  localparam logic [6:0] CAM_ID   = 7'h3C;
  localparam logic [31:0] E_END   = 32'hC000_0000;

  logic clk = 1'b0, rstn = 1'b0, go = 1'b0;
  logic busy, done, err;
  logic [ADDR_W-1:0] err_idx;
  logic [7:0] err_rdata;

  sccb_init_seq_if #(.ADDR_W(ADDR_W)) bus();

  sccb_init_seq #(.ADDR_W(ADDR_W), .CAM_ID(CAM_ID), .TICK_DIV(TICK_DIV), .GAP_CYC(GAP_CYC)) dut (
    .clk(clk), .rstn(rstn), .go(go), .busy(busy), .done(done), .err(err),
    .err_idx(err_idx), .err_rdata(err_rdata), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] rom  [N_ENT];
  logic [7:0]  resp [N_ENT];
  int mlat = 2;
  int mcnt;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // SCCB master model: Busy one cycle after Start, read data appears at end of phase 2
  always @(posedge clk) begin
    if (!rstn) begin
      bus.sccb_busy  <= 1'b0;
      bus.sccb_rdata <= 8'h00;
      mcnt           <= 0;
    end else if (bus.sccb_busy) begin
      if (mcnt == 0) begin
        bus.sccb_busy <= 1'b0;
        if (bus.sccb_wr[1:0] == 2'b10) bus.sccb_rdata <= resp[bus.rom_addr];
      end else begin
        mcnt <= mcnt - 1;
      end
    end else if (bus.sccb_start) begin
      bus.sccb_busy <= 1'b1;
      mcnt          <= mlat;
    end
  end

  logic [3:0]  act_wr[$];
  logic [31:0] act_data[$];
  logic [3:0]  held_wr;
  logic [31:0] held_data;
  int unstable = 0;

  always @(negedge clk) begin
    if (bus.sccb_start) begin
      act_wr.push_back(bus.sccb_wr);
      act_data.push_back(bus.sccb_data);
      held_wr   <= bus.sccb_wr;
      held_data <= bus.sccb_data;
    end else if (bus.sccb_busy && (bus.sccb_wr != held_wr || bus.sccb_data != held_data)) begin
      unstable <= unstable + 1;
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] e_wr(input logic wide, input logic [15:0] a, input logic [7:0] d);
    return {2'b00, wide, 5'b0, a, d};
  endfunction
  function automatic logic [31:0] e_vf(input logic wide, input logic [15:0] a, input logic [7:0] d);
    return {2'b01, wide, 5'b0, a, d};
  endfunction
  function automatic logic [31:0] e_dl(input logic [23:0] t);
    return {2'b10, 6'b0, t};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_end();
    for (int i = 0; i < N_ENT; i++) begin
      rom[i]  = E_END;
      resp[i] = 8'h00;
    end
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!(done && !busy) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(done), 32'd1);
  endtask

  task automatic wait_addr(input logic [ADDR_W-1:0] a, output int c);
    int n = 0;
    while (bus.rom_addr != a && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_addr", 32'(bus.rom_addr), 32'(a));
    c = cyc;
  endtask

  typedef struct {
    logic [31:0] ent;
    logic [7:0]  rsp;
    int          nstart;
    logic [3:0]  wr1;
    logic [31:0] d1;
    logic [3:0]  wr2;
    logic [31:0] d2;
    logic        xerr;
  } vec_t;

  vec_t vt[7];

  initial begin
    int base, n, u0, c1, c2, s1;
    logic [3:0]  exp_wr[$];
    logic [31:0] exp_data[$];
    logic        x_err;
    logic [ADDR_W-1:0] x_idx;
    logic [7:0]  x_rd;

    vt[0] = '{e_wr(1'b1, 16'h3008, 8'h82), 8'h00, 1, 4'b0100, 32'h7830_0882, 4'b0000, 32'h0, 1'b0};
    vt[1] = '{e_wr(1'b0, 16'h0012, 8'h80), 8'h00, 1, 4'b0000, 32'h7812_8000, 4'b0000, 32'h0, 1'b0};
    vt[2] = '{e_vf(1'b1, 16'h300A, 8'h56), 8'h56, 2, 4'b0101, 32'h7830_0A56, 4'b0110, 32'h7800_0000, 1'b0};
    vt[3] = '{e_vf(1'b1, 16'h300A, 8'h56), 8'h55, 2, 4'b0101, 32'h7830_0A56, 4'b0110, 32'h7800_0000, 1'b1};
    vt[4] = '{e_vf(1'b0, 16'h0034, 8'hAB), 8'hAB, 2, 4'b0001, 32'h7834_AB00, 4'b0010, 32'h7800_0000, 1'b0};
    vt[5] = '{e_dl(24'd0), 8'h00, 0, 4'b0000, 32'h0, 4'b0000, 32'h0, 1'b0};
    vt[6] = '{E_END, 8'h00, 0, 4'b0000, 32'h0, 4'b0000, 32'h0, 1'b0};

    fill_end();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_start", 32'(bus.sccb_start), 32'd0);
    chk("rst_wr", 32'(bus.sccb_wr), 32'd0);
    chk("rst_data", bus.sccb_data, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      do_reset();
      fill_end();
      rom[0]  = vt[v].ent;
      resp[0] = vt[v].rsp;
      mlat    = 2;
      base    = act_wr.size();
      u0      = unstable;
      pulse_go();
      wait_done($sformatf("tbl%0d_done", v));
      n = act_wr.size() - base;
      chk($sformatf("tbl%0d_nstart", v), 32'(n), 32'(vt[v].nstart));
      if (vt[v].nstart >= 1 && n >= 1) begin
        chk($sformatf("tbl%0d_wr1", v), 32'(act_wr[base]), 32'(vt[v].wr1));
        chk($sformatf("tbl%0d_data1", v), act_data[base], vt[v].d1);
      end
      if (vt[v].nstart >= 2 && n >= 2) begin
        chk($sformatf("tbl%0d_wr2", v), 32'(act_wr[base+1]), 32'(vt[v].wr2));
        chk($sformatf("tbl%0d_data2", v), act_data[base+1], vt[v].d2);
      end
      chk($sformatf("tbl%0d_err", v), 32'(err), 32'(vt[v].xerr));
      if (vt[v].xerr) begin
        chk($sformatf("tbl%0d_err_idx", v), 32'(err_idx), 32'd0);
        chk($sformatf("tbl%0d_err_rdata", v), 32'(err_rdata), 32'(vt[v].rsp));
      end
      chk($sformatf("tbl%0d_stable", v), 32'(unstable - u0), 32'd0);
    end

    // go timing, single start pulse, done/busy at END, go during FIN ignored
    do_reset();
    fill_end();
    rom[0] = e_wr(1'b1, 16'h3008, 8'h82);
    pulse_go();
    wait_done("pre_done");
    chk("pre_addr", 32'(bus.rom_addr), 32'd1);
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk("go_busy", 32'(busy), 32'd1);
    chk("go_addr", 32'(bus.rom_addr), 32'd0);
    chk("go_done_clr", 32'(done), 32'd0);
    chk("go_start_c1", 32'(bus.sccb_start), 32'd0);
    @(negedge clk);
    chk("go_start_c2", 32'(bus.sccb_start), 32'd0);
    @(negedge clk);
    chk("go_start_c3", 32'(bus.sccb_start), 32'd1);
    @(negedge clk);
    chk("go_start_c4", 32'(bus.sccb_start), 32'd0);
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("fin_done_with_busy_fall", 32'(done), 32'd1);
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    chk("fin_go_ignored_busy", 32'(busy), 32'd0);
    chk("fin_go_ignored_done", 32'(done), 32'd1);

    // first mismatch at 4 sticks despite a later one at 6
    do_reset();
    fill_end();
    rom[0] = e_wr(1'b1, 16'h3008, 8'h82);
    rom[1] = e_wr(1'b0, 16'h0012, 8'h80);
    rom[2] = e_dl(24'd1);
    rom[3] = e_vf(1'b1, 16'h300A, 8'h56); resp[3] = 8'h56;
    rom[4] = e_vf(1'b1, 16'h300A, 8'h56); resp[4] = 8'h55;
    rom[5] = e_wr(1'b1, 16'h3010, 8'h01);
    rom[6] = e_vf(1'b0, 16'h0034, 8'hAB); resp[6] = 8'h11;
    base = act_wr.size();
    pulse_go();
    wait_done("mm_done");
    chk("mm_err", 32'(err), 32'd1);
    chk("mm_err_idx", 32'(err_idx), 32'd4);
    chk("mm_err_rdata", 32'(err_rdata), 32'h55);
    chk("mm_nstart", 32'(act_wr.size() - base), 32'd9);

    // reset during XFER (no do_reset first: err_idx still holds 4)
    fill_end();
    rom[0] = e_wr(1'b1, 16'h3008, 8'h82);
    mlat = 20;
    pulse_go();
    n = 0;
    while (!bus.sccb_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rx_master_busy", 32'(bus.sccb_busy), 32'd1);
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("rx_busy", 32'(busy), 32'd0);
    chk("rx_done", 32'(done), 32'd0);
    chk("rx_err", 32'(err), 32'd0);
    chk("rx_err_idx", 32'(err_idx), 32'd0);
    chk("rx_err_rdata", 32'(err_rdata), 32'd0);
    chk("rx_start", 32'(bus.sccb_start), 32'd0);
    chk("rx_wr", 32'(bus.sccb_wr), 32'd0);
    chk("rx_data", bus.sccb_data, 32'd0);
    chk("rx_addr", 32'(bus.rom_addr), 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // DELAY of 3 ticks: FETCH+DECODE plus 3*TICK_DIV cycles between address steps
    fill_end();
    mlat = 2;
    rom[0] = e_wr(1'b1, 16'h3008, 8'h82);
    rom[1] = e_dl(24'd3);
    pulse_go();
    wait_addr(3'd1, c1);
    s1 = act_wr.size();
    wait_addr(3'd2, c2);
    chk("dly_cycles", 32'(c2 - c1), 32'(2 + 3 * TICK_DIV));
    chk("dly_no_start", 32'(act_wr.size() - s1), 32'd0);
    wait_done("dly_done");

    // full table without END, extra go mid-run must be ignored
    for (int i = 0; i < N_ENT; i++) rom[i] = e_wr(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom));
    mlat = 1;
    base = act_wr.size();
    pulse_go();
    wait_addr(3'd3, c1);
    pulse_go();
    wait_done("full_done");
    chk("full_nstart", 32'(act_wr.size() - base), 32'(N_ENT));
    chk("full_last_addr", 32'(bus.rom_addr), 32'(N_ENT - 1));
    chk("full_err", 32'(err), 32'd0);

    // randomized tables against a table-walk model
    for (int t = 0; t < 20; t++) begin
      int r;
      logic w;
      logic [7:0] d;
      for (int i = 0; i < N_ENT; i++) begin
        r = $urandom_range(0, 9);
        w = 1'($urandom_range(0, 1));
        d = 8'($urandom);
        if (r < 4)      rom[i] = e_wr(w, 16'($urandom), d);
        else if (r < 7) rom[i] = e_vf(w, 16'($urandom), d);
        else if (r < 9) rom[i] = e_dl(24'($urandom_range(0, 2)));
        else            rom[i] = E_END;
        resp[i] = ($urandom_range(0, 1) == 1) ? d : 8'($urandom);
      end
      mlat = $urandom_range(0, 4);

      exp_wr.delete();
      exp_data.delete();
      x_err = 1'b0;
      x_idx = '0;
      x_rd  = 8'h00;
      for (int i = 0; i < N_ENT; i++) begin
        logic [1:0]  op;
        logic        wd;
        logic [31:0] word;
        op   = rom[i][31:30];
        wd   = rom[i][29];
        word = wd ? {CAM_ID, 1'b0, rom[i][23:0]} : {CAM_ID, 1'b0, rom[i][15:0], 8'h00};
        if (op == 2'b11) break;
        if (op == 2'b00) begin
          exp_wr.push_back(wd ? 4'b0100 : 4'b0000);
          exp_data.push_back(word);
        end else if (op == 2'b01) begin
          exp_wr.push_back(wd ? 4'b0101 : 4'b0001);
          exp_data.push_back(word);
          exp_wr.push_back(wd ? 4'b0110 : 4'b0010);
          exp_data.push_back({CAM_ID, 1'b0, 24'h0});
          if (resp[i] != rom[i][7:0] && !x_err) begin
            x_err = 1'b1;
            x_idx = ADDR_W'(i);
            x_rd  = resp[i];
          end
        end
      end

      base = act_wr.size();
      pulse_go();
      wait_done($sformatf("rnd%0d_done", t));
      n = act_wr.size() - base;
      chk($sformatf("rnd%0d_nstart", t), 32'(n), 32'(exp_wr.size()));
      for (int k = 0; k < exp_wr.size() && k < n; k++) begin
        chk($sformatf("rnd%0d_wr%0d", t, k), 32'(act_wr[base+k]), 32'(exp_wr[k]));
        chk($sformatf("rnd%0d_data%0d", t, k), act_data[base+k], exp_data[k]);
      end
      chk($sformatf("rnd%0d_err", t), 32'(err), 32'(x_err));
      if (x_err) begin
        chk($sformatf("rnd%0d_err_idx", t), 32'(err_idx), 32'(x_idx));
        chk($sformatf("rnd%0d_err_rdata", t), 32'(err_rdata), 32'(x_rd));
      end
    end

    chk("stable_all", 32'(unstable), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sccb_init_seq.md
# sccb_init_seq

Table-driven sequencer that issues camera register programming through the SCCB master. It fetches 32-bit command words from an external synchronous ROM/BRAM, drives the master's Start/WR/DataIn, and waits on its Busy. It executes writes, read-back verifies and timed delays, then reports done and error status. It sits between the PS/GPIO control registers and the SCCB master in the Tx camera path.

## Interface
- `ADDR_W`, 8: table address width; max 2^ADDR_W entries.
- `CAM_ID`, 7'h3C: 7-bit SCCB device ID placed in DataIn[31:25].
- `TICK_DIV`, 100000: clk cycles per delay tick (1 ms at 100 MHz).
- `GAP_CYC`, 16: minimum idle clk cycles between consecutive SCCB transactions.

- `clk` in 1: system clock.
- `rstn` in 1: reset, synchronous, active-low.
- `go` in 1: one-cycle pulse; starts the sequence from entry 0. Ignored while `busy`.
- `busy` out 1: sequence running.
- `done` out 1: sticky; set at END; cleared by next accepted `go`.
- `err` out 1: sticky verify mismatch; cleared by next accepted `go`.
- `err_idx` out ADDR_W: index of the first mismatching entry.
- `err_rdata` out 8: byte read at the first mismatch.
- `rom_addr` out ADDR_W: table read address.
- `rom_data` in 32: table word, valid 1 cycle after `rom_addr`.
- `sccb_start` out 1: one-cycle Start pulse to the master.
- `sccb_wr` out 4: WR to master. [3:2]=01 for 16-bit register address, 00 for 8-bit. [1:0]: 00 write, 01 read phase 1, 10 read phase 2.
- `sccb_data` out 32: DataIn to master.
- `sccb_busy` in 1: master Busy.
- `sccb_rdata` in 8: master ReadData.

## Operation
- Entry format: [31:30] op, [29] wide, [28:24] reserved (0), [23:8] reg address, [7:0] data. For op DELAY, [23:0] is the tick count.
- Op codes:
  - 00 WRITE
  - 01 VERIFY: read the register, compare to [7:0].
  - 10 DELAY
  - 11 END
- DataIn, wide=1: {CAM_ID, 1'b0, addr[15:8], addr[7:0], data}.
- DataIn, wide=0: {CAM_ID, 1'b0, addr[7:0], data, 8'h00}.
- DataIn, read phase 2: {CAM_ID, 1'b0, 24'h0}.
- State list: IDLE, FETCH, DECODE, ISSUE, ACK, XFER, GAP, RD2_ISSUE, RD2_ACK, RD2_XFER, CMP, DELAY, FIN.
- Transitions:
  - IDLE -go-> FETCH. Index=0; clear done/err.
  - FETCH -> DECODE after one cycle (ROM latency).
  - DECODE routes by op:
    - WRITE/VERIFY -> ISSUE.
    - DELAY -> DELAY; a count of 0 goes straight to the next FETCH.
    - END -> FIN.
  - ISSUE: `sccb_start`=1 for exactly one cycle -> ACK.
  - ACK: wait for `sccb_busy`=1 -> XFER.
  - XFER: wait for `sccb_busy`=0 -> GAP.
  - GAP: count GAP_CYC cycles. Then:
    - after read phase 1 -> RD2_ISSUE;
    - otherwise (write or read phase 2) -> next FETCH, or CMP after phase 2.
  - RD2_ISSUE/RD2_ACK/RD2_XFER mirror ISSUE/ACK/XFER with WR[1:0]=10.
  - CMP: compare `sccb_rdata` with entry data.
    - On mismatch with err=0: set err and capture err_idx/err_rdata. Later mismatches do not overwrite.
    - Always continue to FETCH.
  - DELAY: count ticks×TICK_DIV cycles -> FETCH.
  - FIN: set done -> IDLE.
- `sccb_wr`/`sccb_data` are registered in DECODE (and RD2_ISSUE). They are held stable until the transaction's XFER exit; the master samples WR combinationally throughout Busy.
- Index wrap: if the entry at index 2^ADDR_W-1 is not END, it executes and then the sequencer goes to FIN. The index never wraps to 0.
- Reset mid-operation → IDLE, all outputs at reset values. The master is reset independently.

## Timing
- Reset values:
  - `busy`, `done`, `err`, `sccb_start`: 0.
  - `err_idx`, `err_rdata`, `rom_addr`: 0.
  - `sccb_wr`: 4'b0000.
  - `sccb_data`: 0.
- go → `rom_addr` valid the next cycle; `busy`=1 the cycle after go.
- `sccb_start` rises 3 cycles after go (IDLE→FETCH→DECODE→ISSUE).
- Master Busy rises 1 cycle after Start. ACK has no timeout.
- Per WRITE entry: 3 + master transaction + GAP_CYC cycles.
- DELAY of N ticks: N×TICK_DIV cycles in DELAY, ±0.
- `done` sets the cycle after DECODE sees END. `busy` falls the same cycle.
- go coincident with FIN: ignored; a new go is accepted once in IDLE.

## Structure
- Shared package `sccb_pkg`:
  - op-code constants;
  - WR encodings (WR_WRITE, WR_RD1, WR_RD2, WR_WIDE);
  - state enum;
  - entry field positions.
  The SCCB master also uses WR_* from this package.
- One natural sub-module, `tick_timer`, serves both GAP and DELAY:
  - load a count, count down at a clk or tick rate, raise `expired`.
- ROM contents live outside the block.

## Test plan
- Single WRITE, wide=1, addr 16'h3008, data 8'h82, then END:
  - exactly one start pulse;
  - sccb_wr=4'b0100, sccb_data=32'h78300882;
  - done=1, err=0.
- Narrow WRITE, addr 8'h12, data 8'h80:
  - sccb_wr=4'b0000, sccb_data=32'h78128000;
  - data held stable until master Busy falls.
- VERIFY, addr 16'h300A, data 8'h56, bus model returns 8'h56:
  - two starts, WR 0101 then 0110; err=0.
- Same VERIFY with model returning 8'h55 at index 4, a later mismatch at index 6:
  - err=1, err_idx=4, err_rdata=8'h55; sequence still reaches done.
- DELAY of 3 ticks with TICK_DIV=10:
  - the next rom_addr change comes exactly 30 cycles after DELAY entry;
  - no sccb_start during the delay.
- rstn low mid-XFER, then go asserted again:
  - outputs return to reset values the cycle after rstn is sampled low;
  - go while busy is ignored;
  - a full table with no END executes all 2^ADDR_W entries, then sets done.
